freq_divbyeven: RTL and testbench

// - Even-ratio clock divider: produces clk_div at f(clk)/NUM_DIV with 50% duty cycle.
// - Used wherever a slower, phase-aligned, glitch-free derived clock or enable waveform is needed.
// - Output is registered in the clk domain, so there are no combinational glitches.
//

---
 rtl/freq_divbyeven.sv | 43 ++++
 tb/tb_freq_divbyeven.sv | 108 ++++++++++
 2 files changed

// File: rtl/freq_divbyeven.sv
// Even-ratio clock divider: clk_div runs at f(clk)/NUM_DIV with a 50% duty cycle.
// The output comes straight from a flop, so it is glitch-free and phase-aligned to clk.
module freq_divbyeven #(
  parameter int NUM_DIV = 6,
  parameter int CNT_W   = (NUM_DIV / 2 > 1) ? $clog2(NUM_DIV / 2) : 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_div
);

  localparam int              HALF     = NUM_DIV / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  // An odd ratio cannot give 50% duty with a single-edge design.
  generate
    if ((NUM_DIV < 2) || (NUM_DIV % 2 != 0)) begin : g_bad_num_div
      $error("freq_divbyeven: NUM_DIV must be even and >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic             clk_div_r;

  // rst_n is active-high and synchronous here; it wins over counting.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt       <= '0;
      clk_div_r <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt       <= '0;
      clk_div_r <= ~clk_div_r;
    end else if (cnt > CNT_LAST) begin
      cnt       <= '0;
    end else begin
      cnt       <= cnt + 1'b1;
    end
  end

  assign clk_div = clk_div_r;

endmodule

// File: tb/tb_freq_divbyeven.sv
// Bench for freq_divbyeven: four ratios share clk/reset; expected outputs come from
// the number of edges elapsed since reset release.
module tb_freq_divbyeven;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic div6, div2, div4, div10;

  int n_cmp = 0;
  int n_bad = 0;

  int halves [4] = '{3, 1, 2, 5};
  int edges  [4] = '{0, 0, 0, 0};

  // Long-run measurement state for the default ratio.
  bit measuring = 1'b0;
  int rises = 0;
  int last_change = -1;
  logic prev6 = 1'b0;

  always #5 clk = ~clk;

  freq_divbyeven #(.NUM_DIV(6))  u_div6  (.clk(clk), .rst_n(rst_n), .clk_div(div6));
  freq_divbyeven #(.NUM_DIV(2))  u_div2  (.clk(clk), .rst_n(rst_n), .clk_div(div2));
  freq_divbyeven #(.NUM_DIV(4))  u_div4  (.clk(clk), .rst_n(rst_n), .clk_div(div4));
  freq_divbyeven #(.NUM_DIV(10)) u_div10 (.clk(clk), .rst_n(rst_n), .clk_div(div10));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic out_of(input int i);
    case (i)
      0:       return div6;
      1:       return div2;
      2:       return div4;
      default: return div10;
    endcase
  endfunction

  // Output is high during the odd-numbered half periods after release.
  function automatic logic model(input int i);
    return logic'((edges[i] / halves[i]) % 2);
  endfunction

  // Drive reset, take one rising edge, then compare every ratio mid-cycle.
  task automatic step(input logic r);
    rst_n = r;
    @(posedge clk);
    for (int i = 0; i < 4; i++) edges[i] = r ? 0 : edges[i] + 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("div%0d_edge%0d", 2 * halves[i], edges[i]), 32'(out_of(i)), 32'(model(i)));
    if (measuring && (div6 !== prev6)) begin
      if (div6 === 1'b1) rises++;
      if (last_change >= 0) check("div6_phase_len", edges[0] - last_change, 3);
      last_change = edges[0];
    end
    prev6 = div6;
  endtask

  initial begin
    // Reset hold over the first edge, then the default-ratio waveform.
    step(1'b1);
    check("reset_hold", 32'(div6), 32'd0);
    for (int k = 0; k < 9; k++) step(1'b0);
    check("default_edge9_high", 32'(div6), 32'd1);

    // Long run: 120 cycles from a fresh release.
    step(1'b1);
    prev6 = div6;
    measuring = 1'b1;
    for (int k = 0; k < 120; k++) step(1'b0);
    measuring = 1'b0;
    check("rise_count_120", rises, 20);

    // Mid-operation reset with div6 high and its counter at 1 (post-release edge 4).
    step(1'b1);
    for (int k = 0; k < 4; k++) step(1'b0);
    check("mid_pre_high", 32'(div6), 32'd1);
    step(1'b1);
    check("mid_cleared", 32'(div6), 32'd0);
    step(1'b0);
    step(1'b0);
    check("mid_edge2_low", 32'(div6), 32'd0);
    step(1'b0);
    check("mid_edge3_rise", 32'(div6), 32'd1);

    // Randomized runs separated by reset pulses (one-edge glitches or longer).
    for (int it = 0; it < 25; it++) begin
      int run_len = $urandom_range(1, 25);
      int rst_len = $urandom_range(1, 2);
      for (int k = 0; k < run_len; k++) step(1'b0);
      for (int k = 0; k < rst_len; k++) step(1'b1);
      check("rand_reset_clear", 32'({div10, div4, div2, div6}), 32'd0);
      step(1'b0);
      check("rand_resume_div2", 32'(div2), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
